sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter DB_CNT, default 500000, meaning consecutive stable cycles required to accept a switch level (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, meaning width of each per-bit stability counter.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port switch, input, 8, raw asynchronous DIP-switch levels (SW1 = bit 0).
REQ-006 SHALL have port switch_db, output, 8, debounced switch levels, driven directly to the LED stage.
REQ-007 SHALL have port sw_rise, output, 8, per-bit one-cycle pulse on an accepted 0->1 change.
REQ-008 SHALL have port sw_fall, output, 8, per-bit one-cycle pulse on an accepted 1->0 change.
REQ-009 SHALL have port sw_changed, output, 1, OR of all bits of sw_rise and sw_fall.

Function
REQ-010 SHALL pass each switch bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL keep one CNT_W-bit counter per bit; bits are fully independent.
REQ-012 SHALL clear counter[i] whenever sync2[i] equals switch_db[i].
REQ-013 SHALL increment counter[i] by 1 each cycle sync2[i] differs from switch_db[i] and counter[i] < DB_CNT-1.
REQ-014 SHALL, on the cycle sync2[i] differs and counter[i] == DB_CNT-1, load switch_db[i] <= sync2[i] and clear counter[i].
REQ-015 SHALL therefore accept a new level only after DB_CNT consecutive differing samples; any agreeing sample (bounce) restarts the count at 0.
REQ-016 SHALL give latency from a stable input change (setup before edge N) to switch_db update of exactly DB_CNT+2 clock edges (edge N+DB_CNT+1).
REQ-017 SHALL assert sw_rise[i] or sw_fall[i] (registered) for exactly one cycle, in the same cycle the new switch_db[i] value first appears.
REQ-018 SHALL never assert sw_rise[i] and sw_fall[i] simultaneously; different bits MAY pulse in the same cycle, producing one sw_changed cycle.
REQ-019 SHALL never let counters wrap; DB_CNT shall satisfy 1 <= DB_CNT <= 2^CNT_W - 1.
REQ-020 SHALL, with DB_CNT = 1, update switch_db one cycle after sync2 differs (pure 3-flop delay, no filtering).
REQ-021 SHALL make no assumption about switch pattern; all 8 bits toggling in the same cycle behave as 8 independent channels.

Reset
REQ-022 SHALL, while rst is high on a clock edge, clear sync1, sync2, all counters, switch_db, sw_rise, sw_fall, sw_changed to 0.
REQ-023 SHALL, on reset asserted mid-count, discard the partial count; no pulse is emitted for that change.
REQ-024 SHALL, after reset release with a switch held at 1, produce switch_db=1 with one sw_rise pulse DB_CNT+2 edges later.

Verification (DB_CNT=4, CNT_W=3)
REQ-025 Reset, switch=0x00 then 0x01 stable -> switch_db=0x01 exactly 6 edges after change, sw_rise=0x01 and sw_changed=1 for one cycle.
REQ-026 switch[3] toggles 1,0,1,0,1 every 2 cycles then holds 1 -> no output change during bounce; switch_db[3]=1 6 edges after final edge only.
REQ-027 switch_db=0xFF, switch=0x00 -> switch_db=0x00 after 6 edges, sw_fall=0xFF for one cycle, sw_rise=0x00 throughout.
REQ-028 switch=0x81 with bit 0 glitching low for 3 cycles -> switch_db[0] stays 1, no sw_fall, bit 7 unaffected.
REQ-029 rst asserted 2 cycles into a 0->1 count on bit 5 -> all outputs 0; after release with switch[5]=1, sw_rise[5] one pulse 6 edges later.
REQ-030 Random switch stimulus vs reference model for 10^5 cycles -> switch_db, pulses match model cycle-exact.

Source files
------------

// File: rtl/sw_debounce.sv
// Eight-channel DIP switch debouncer: two-flop synchronizer, per-bit
// stability counter, and registered rise/fall pulses aligned with switch_db.
module sw_debounce #(
    parameter int DB_CNT = 500000,
    parameter int CNT_W  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] switch,
    output logic [7:0] switch_db,
    output logic [7:0] sw_rise,
    output logic [7:0] sw_fall,
    output logic       sw_changed
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(DB_CNT - 1);

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_db;
    logic [7:0]       r_rise;
    logic [7:0]       r_fall;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt [8];

    logic [7:0]       w_diff;
    logic [7:0]       w_hit;

    assign w_diff = r_sync2 ^ r_db;

    // A hit is the DB_CNT-th consecutive sample disagreeing with switch_db.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 8; i++) begin
            w_hit[i] = w_diff[i] && (r_cnt[i] == LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_chg   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= switch;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 8; i++) begin
                if (!w_diff[i] || w_hit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            // A hit only occurs on a differing bit, so flipping loads sync2.
            r_db   <= r_db ^ w_hit;
            r_rise <= w_hit & r_sync2;
            r_fall <= w_hit & ~r_sync2;
            r_chg  <= |w_hit;
        end
    end

    assign switch_db  = r_db;
    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign sw_changed = r_chg;

endmodule
